// File: rtl/decode_stage.sv
// decode_stage: registered multi-lane instruction decoder between fetch and rename.
// Each lane is decoded combinationally on the input side. Only the decoded
// records are stored, in a 2-entry skid buffer with valid/ready on both sides.
// if_ready_o depends only on the stored count, so id_ready_i has no
// combinational path back to fetch.
module decode_stage #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DECODE_WIDTH = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               if_valid_i,
  output logic                               if_ready_o,
  input  logic [ADDR_WIDTH-1:0]              if_addr_i,
  input  logic [DECODE_WIDTH*32-1:0]         if_instr_i,
  input  logic [DECODE_WIDTH-1:0]            if_lane_valid_i,
  output logic                               id_valid_o,
  input  logic                               id_ready_i,
  output logic [DECODE_WIDTH-1:0]            id_lane_valid_o,
  output logic [DECODE_WIDTH*ADDR_WIDTH-1:0] id_addr_o,
  output logic [DECODE_WIDTH*7-1:0]          id_opcode_o,
  output logic [DECODE_WIDTH*3-1:0]          id_funct3_o,
  output logic [DECODE_WIDTH*7-1:0]          id_funct7_o,
  output logic [DECODE_WIDTH*5-1:0]          id_rd_o,
  output logic [DECODE_WIDTH*5-1:0]          id_rs1_o,
  output logic [DECODE_WIDTH*5-1:0]          id_rs2_o,
  output logic [DECODE_WIDTH*DATA_WIDTH-1:0] id_imm_o,
  output logic [DECODE_WIDTH-1:0]            id_rd_we_o,
  output logic [DECODE_WIDTH-1:0]            id_rs1_used_o,
  output logic [DECODE_WIDTH-1:0]            id_rs2_used_o,
  output logic [DECODE_WIDTH-1:0]            id_illegal_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic                  lane_valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [DATA_WIDTH-1:0] imm;
    logic                  rd_we;
    logic                  rs1_used;
    logic                  rs2_used;
    logic                  illegal;
  } lane_rec_t;

  typedef lane_rec_t [DECODE_WIDTH-1:0] bundle_t;

  // Decode one instruction into a stored record. Masked lanes come out all
  // zero; illegal lanes keep only address and opcode so rename can trap.
  function automatic lane_rec_t decode_lane(input logic [31:0]           instr,
                                            input logic [ADDR_WIDTH-1:0] addr,
                                            input logic                  valid);
    lane_rec_t   rec;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm32;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_f3;
    logic        use_f7;
    logic        legal;

    rec     = '0;
    opc     = instr[6:0];
    f3      = instr[14:12];
    f7      = instr[31:25];
    imm32   = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_f3  = 1'b0;
    use_f7  = 1'b0;
    legal   = 1'b1;

    i_imm = {{20{instr[31]}}, instr[31:20]};
    s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    u_imm = {instr[31:12], 12'b0};
    j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    case (opc)
      OPC_LOAD: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_f3  = 1'b1;
        imm32   = i_imm;
        legal   = !(f3 inside {3'b011, 3'b110, 3'b111});
      end
      OPC_OP_IMM: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_f3  = 1'b1;
        imm32   = i_imm;
        // shift-immediates carry funct7 and constrain it
        if (f3 == 3'b001) begin
          use_f7 = 1'b1;
          legal  = (f7 == F7_ZERO);
        end else if (f3 == 3'b101) begin
          use_f7 = 1'b1;
          legal  = (f7 == F7_ZERO) || (f7 == F7_ALT);
        end
      end
      OPC_JALR: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_f3  = 1'b1;
        imm32   = i_imm;
        legal   = (f3 == 3'b000);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_f3  = 1'b1;
        imm32   = s_imm;
        legal   = (f3 <= 3'b010);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_f3  = 1'b1;
        imm32   = b_imm;
        legal   = !(f3 inside {3'b010, 3'b011});
      end
      OPC_OP: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_f3  = 1'b1;
        use_f7  = 1'b1;
        legal   = (f7 == F7_ZERO) ||
                  ((f7 == F7_ALT) && (f3 inside {3'b000, 3'b101}));
      end
      OPC_LUI, OPC_AUIPC: begin
        use_rd = 1'b1;
        imm32  = u_imm;
      end
      OPC_JAL: begin
        use_rd = 1'b1;
        imm32  = j_imm;
      end
      default: legal = 1'b0;
    endcase

    if (valid) begin
      rec.lane_valid = 1'b1;
      rec.addr       = addr;
      rec.opcode     = opc;
      if (!legal) begin
        rec.illegal = 1'b1;
      end else begin
        rec.rd       = use_rd  ? instr[11:7]  : 5'd0;
        rec.rs1      = use_rs1 ? instr[19:15] : 5'd0;
        rec.rs2      = use_rs2 ? instr[24:20] : 5'd0;
        rec.funct3   = use_f3  ? f3 : 3'd0;
        rec.funct7   = use_f7  ? f7 : 7'd0;
        rec.imm      = DATA_WIDTH'($signed(imm32));
        rec.rd_we    = use_rd && (instr[11:7] != 5'd0);
        rec.rs1_used = use_rs1;
        rec.rs2_used = use_rs2;
      end
    end
    return rec;
  endfunction

  bundle_t    dec_bundle;
  bundle_t    mem_q [2];
  bundle_t    head_bundle;
  logic [1:0] count_q, count_d;
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic       push;
  logic       pop;

  // Decode every lane of the incoming fetch bundle.
  always_comb begin
    dec_bundle = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      dec_bundle[i] = decode_lane(if_instr_i[32*i +: 32],
                                  if_addr_i + ADDR_WIDTH'(4 * i),
                                  if_lane_valid_i[i]);
    end
  end

  assign if_ready_o = (count_q != 2'd2);
  assign id_valid_o = (count_q != 2'd0);

  // Handshakes; an all-zero lane mask is accepted but never stored.
  assign push = if_valid_i & if_ready_o & (|if_lane_valid_i) & ~flush_i;
  assign pop  = id_valid_o & id_ready_i & ~flush_i;

  // Next-state for occupancy and pointers; flush empties the buffer outright.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset also clears the stored bundles so outputs read zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (push) mem_q[tail_q] <= dec_bundle;
    end
  end

  assign head_bundle = mem_q[head_q];

  // Spread the head entry onto the flat per-lane output buses.
  always_comb begin
    id_lane_valid_o = '0;
    id_addr_o       = '0;
    id_opcode_o     = '0;
    id_funct3_o     = '0;
    id_funct7_o     = '0;
    id_rd_o         = '0;
    id_rs1_o        = '0;
    id_rs2_o        = '0;
    id_imm_o        = '0;
    id_rd_we_o      = '0;
    id_rs1_used_o   = '0;
    id_rs2_used_o   = '0;
    id_illegal_o    = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      id_lane_valid_o[i]                    = head_bundle[i].lane_valid;
      id_addr_o[ADDR_WIDTH*i +: ADDR_WIDTH] = head_bundle[i].addr;
      id_opcode_o[7*i +: 7]                 = head_bundle[i].opcode;
      id_funct3_o[3*i +: 3]                 = head_bundle[i].funct3;
      id_funct7_o[7*i +: 7]                 = head_bundle[i].funct7;
      id_rd_o[5*i +: 5]                     = head_bundle[i].rd;
      id_rs1_o[5*i +: 5]                    = head_bundle[i].rs1;
      id_rs2_o[5*i +: 5]                    = head_bundle[i].rs2;
      id_imm_o[DATA_WIDTH*i +: DATA_WIDTH]  = head_bundle[i].imm;
      id_rd_we_o[i]                         = head_bundle[i].rd_we;
      id_rs1_used_o[i]                      = head_bundle[i].rs1_used;
      id_rs2_used_o[i]                      = head_bundle[i].rs2_used;
      id_illegal_o[i]                       = head_bundle[i].illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// queue-based reference model of the decode rules and the 2-deep buffer.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_addr;
  logic [63:0] if_instr;
  logic [1:0]  if_lane_valid;
  logic        id_valid;
  logic        id_ready;
  logic [1:0]  id_lane_valid;
  logic [63:0] id_addr;
  logic [13:0] id_opcode;
  logic [5:0]  id_funct3;
  logic [13:0] id_funct7;
  logic [9:0]  id_rd;
  logic [9:0]  id_rs1;
  logic [9:0]  id_rs2;
  logic [63:0] id_imm;
  logic [1:0]  id_rd_we;
  logic [1:0]  id_rs1_used;
  logic [1:0]  id_rs2_used;
  logic [1:0]  id_illegal;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        lv;
    logic [31:0] addr;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        we;
    logic        u1;
    logic        u2;
    logic        ill;
  } exp_t;

  typedef exp_t [1:0] bexp_t;

  bexp_t mq[$];

  logic [6:0] opc_tbl [9] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                              7'b1100011, 7'b0110011, 7'b0110111, 7'b0010111,
                              7'b1101111};

  decode_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DECODE_WIDTH(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .if_valid_i      (if_valid),
    .if_ready_o      (if_ready),
    .if_addr_i       (if_addr),
    .if_instr_i      (if_instr),
    .if_lane_valid_i (if_lane_valid),
    .id_valid_o      (id_valid),
    .id_ready_i      (id_ready),
    .id_lane_valid_o (id_lane_valid),
    .id_addr_o       (id_addr),
    .id_opcode_o     (id_opcode),
    .id_funct3_o     (id_funct3),
    .id_funct7_o     (id_funct7),
    .id_rd_o         (id_rd),
    .id_rs1_o        (id_rs1),
    .id_rs2_o        (id_rs2),
    .id_imm_o        (id_imm),
    .id_rd_we_o      (id_rd_we),
    .id_rs1_used_o   (id_rs1_used),
    .id_rs2_used_o   (id_rs2_used),
    .id_illegal_o    (id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the opcode table and illegal-encoding list.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a, input logic v);
    exp_t e;
    int   s;
    int   imm;
    int   f3;
    int   f7;
    bit   has_rd, has_rs1, has_rs2, has_f3, has_f7, ok;
    e = '0;
    s = int'($signed(ins));
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    imm = 0;
    has_rd = 0; has_rs1 = 0; has_rs2 = 0; has_f3 = 0; has_f7 = 0; ok = 1;
    if (!v) return e;
    e.lv = 1'b1;
    e.addr = a;
    e.opc = ins[6:0];
    case (ins[6:0])
      7'b0000011: begin has_rd = 1; has_rs1 = 1; has_f3 = 1; imm = s >>> 20;
                        ok = !(f3 == 3 || f3 == 6 || f3 == 7); end
      7'b0010011: begin has_rd = 1; has_rs1 = 1; has_f3 = 1; imm = s >>> 20;
                        if (f3 == 1) begin has_f7 = 1; ok = (f7 == 0); end
                        if (f3 == 5) begin has_f7 = 1; ok = (f7 == 0 || f7 == 32); end
                  end
      7'b1100111: begin has_rd = 1; has_rs1 = 1; has_f3 = 1; imm = s >>> 20; ok = (f3 == 0); end
      7'b0100011: begin has_rs1 = 1; has_rs2 = 1; has_f3 = 1;
                        imm = (s >>> 25) * 32 + int'(ins[11:7]); ok = (f3 <= 2); end
      7'b1100011: begin has_rs1 = 1; has_rs2 = 1; has_f3 = 1;
                        imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048
                              + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                        ok = !(f3 == 2 || f3 == 3); end
      7'b0110011: begin has_rd = 1; has_rs1 = 1; has_rs2 = 1; has_f3 = 1; has_f7 = 1;
                        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)); end
      7'b0110111, 7'b0010111: begin has_rd = 1; imm = s - int'(ins[11:0]); end
      7'b1101111: begin has_rd = 1;
                        imm = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096
                              + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2; end
      default: ok = 0;
    endcase
    if (!ok) begin
      e.ill = 1'b1;
      return e;
    end
    if (has_rd)  e.rd  = ins[11:7];
    if (has_rs1) e.rs1 = ins[19:15];
    if (has_rs2) e.rs2 = ins[24:20];
    if (has_f3)  e.f3  = ins[14:12];
    if (has_f7)  e.f7  = ins[31:25];
    e.imm = imm;
    e.we  = has_rd && (ins[11:7] != 0);
    e.u1  = has_rs1;
    e.u2  = has_rs2;
    return e;
  endfunction

  function automatic exp_t dut_lane(input int i);
    exp_t e;
    e.lv   = id_lane_valid[i];
    e.addr = id_addr[i*32 +: 32];
    e.opc  = id_opcode[i*7 +: 7];
    e.f3   = id_funct3[i*3 +: 3];
    e.f7   = id_funct7[i*7 +: 7];
    e.rd   = id_rd[i*5 +: 5];
    e.rs1  = id_rs1[i*5 +: 5];
    e.rs2  = id_rs2[i*5 +: 5];
    e.imm  = id_imm[i*32 +: 32];
    e.we   = id_rd_we[i];
    e.u1   = id_rs1_used[i];
    e.u2   = id_rs2_used[i];
    e.ill  = id_illegal[i];
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) r[6:0] = opc_tbl[k];
    if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return r;
  endfunction

  // Check outputs against the model, advance the model with this cycle's
  // inputs, then step one clock.
  task automatic cycle();
    bexp_t b;
    bit    pu;
    bit    po;
    chk_val("if_ready", if_ready, mq.size() < 2);
    chk_val("id_valid", id_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      for (int i = 0; i < 2; i++) chk_val($sformatf("lane%0d", i), dut_lane(i), mq[0][i]);
    end
    if (rst || flush) begin
      mq.delete();
    end else begin
      pu = if_valid && (mq.size() < 2) && (if_lane_valid != 2'b00);
      po = (mq.size() != 0) && id_ready;
      if (po) void'(mq.pop_front());
      if (pu) begin
        for (int i = 0; i < 2; i++)
          b[i] = ref_decode(if_instr[32*i +: 32], if_addr + 32'(4 * i), if_lane_valid[i]);
        mq.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [63:0] ins, input logic [1:0] m);
    if_valid      = v;
    if_addr       = a;
    if_instr      = ins;
    if_lane_valid = m;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 2'b00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mq.delete();
    rst = 1'b0;

    // reset state
    chk_val("rst_outs", {id_lane_valid, id_addr, id_opcode, id_funct3, id_funct7, id_rd, id_rs1,
                         id_rs2, id_imm, id_rd_we, id_rs1_used, id_rs2_used, id_illegal}, '0);

    // decode values: addi / sw
    id_ready = 1'b1;
    drive(1'b1, 32'h1000, {32'h0021A423, 32'hFFF00093}, 2'b11);
    cycle();
    drive(1'b0, 32'h0, 64'h0, 2'b00);
    chk_val("addi_opc", id_opcode[6:0], 7'b0010011);
    chk_val("addi_rd", id_rd[4:0], 5'd1);
    chk_val("addi_rs1", id_rs1[4:0], 5'd0);
    chk_val("addi_imm", id_imm[31:0], 32'hFFFFFFFF);
    chk_val("addi_flags", {id_rd_we[0], id_rs1_used[0]}, 2'b11);
    chk_val("sw_rs", {id_rs1[9:5], id_rs2[9:5]}, {5'd3, 5'd2});
    chk_val("sw_f3", id_funct3[5:3], 3'b010);
    chk_val("sw_imm", id_imm[63:32], 32'h00000008);
    chk_val("sw_rd", {id_rd[9:5], id_rd_we[1]}, 6'd0);
    chk_val("sw_addr", id_addr[63:32], 32'h1004);
    cycle();

    // branch / illegal OP
    drive(1'b1, 32'h2000, {32'h402091B3, 32'hFE000EE3}, 2'b11);
    cycle();
    drive(1'b0, 32'h0, 64'h0, 2'b00);
    chk_val("beq_imm", id_imm[31:0], 32'hFFFFFFFC);
    chk_val("beq_use", {id_rs1_used[0], id_rs2_used[0]}, 2'b11);
    chk_val("ill_flag", id_illegal[1], 1'b1);
    chk_val("ill_rd", {id_rd[9:5], id_rd_we[1]}, 6'd0);
    chk_val("ill_opc", id_opcode[13:7], 7'b0110011);
    cycle();

    // backpressure A, B, C
    id_ready = 1'b0;
    drive(1'b1, 32'hA000, {rand_instr(), rand_instr()}, 2'b11);
    cycle();
    drive(1'b1, 32'hB000, {rand_instr(), rand_instr()}, 2'b11);
    cycle();
    drive(1'b1, 32'hC000, {rand_instr(), rand_instr()}, 2'b11);
    chk_val("bp_full", if_ready, 1'b0);
    cycle();
    cycle();
    id_ready = 1'b1;
    chk_val("bp_A", id_addr[31:0], 32'hA000);
    cycle();
    chk_val("bp_B", id_addr[31:0], 32'hB000);
    cycle();
    drive(1'b0, 32'h0, 64'h0, 2'b00);
    chk_val("bp_C", id_addr[31:0], 32'hC000);
    cycle();

    // streaming with simultaneous push and pop
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, 32'h3000 + 32'(16 * n), {rand_instr(), rand_instr()}, 2'b11);
      if (n > 0) chk_val("stream_rdy", if_ready, 1'b1);
      cycle();
    end
    drive(1'b0, 32'h0, 64'h0, 2'b00);
    cycle();

    // flush with a full buffer and a valid input
    id_ready = 1'b0;
    drive(1'b1, 32'h4000, {rand_instr(), rand_instr()}, 2'b11);
    cycle();
    drive(1'b1, 32'h4100, {rand_instr(), rand_instr()}, 2'b11);
    cycle();
    drive(1'b1, 32'h4200, {rand_instr(), rand_instr()}, 2'b11);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 2'b00);
    chk_val("flush_vld", id_valid, 1'b0);
    chk_val("flush_rdy", if_ready, 1'b1);
    id_ready = 1'b1;
    cycle();
    cycle();

    // lane mask 10
    drive(1'b1, 32'h5000, {32'hFFF00093, 32'hFFF00093}, 2'b10);
    cycle();
    drive(1'b0, 32'h0, 64'h0, 2'b00);
    chk_val("mask_lv", id_lane_valid, 2'b10);
    chk_val("mask_l0", dut_lane(0), '0);
    cycle();

    // lane mask 00 is dropped
    drive(1'b1, 32'h6000, {rand_instr(), rand_instr()}, 2'b00);
    cycle();
    drive(1'b0, 32'h0, 64'h0, 2'b00);
    chk_val("mask0_vld", id_valid, 1'b0);
    cycle();

    // reset mid-stream
    id_ready = 1'b0;
    drive(1'b1, 32'h7000, {rand_instr(), rand_instr()}, 2'b11);
    cycle();
    drive(1'b1, 32'h7100, {rand_instr(), rand_instr()}, 2'b11);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 64'h0, 2'b00);
    chk_val("rst_vld", id_valid, 1'b0);
    chk_val("rst_mid_outs", {id_lane_valid, id_addr, id_opcode, id_funct3, id_funct7, id_rd, id_rs1,
                             id_rs2, id_imm, id_rd_we, id_rs1_used, id_rs2_used, id_illegal}, '0);
    cycle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 9) < 7, $urandom & 32'hFFFFFFFC, {rand_instr(), rand_instr()},
            2'($urandom_range(0, 3)));
      id_ready = $urandom_range(0, 9) < 6;
      flush    = $urandom_range(0, 99) < 3;
      rst      = $urandom_range(0, 99) < 1;
      cycle();
    end
    rst = 1'b0; flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
